// File: rtl/dmem_ctrl.sv
// dmem_ctrl: multi-cycle data-memory controller for the CPU load/store port.
// Word-organised RAM with byte-lane writes, fixed wait states, a stall output
// that freezes the CPU, and misaligned-access flagging instead of execution.
// Optional feature macro: DMEM_STATS_EN adds saturating ld_count/st_count.
module dmem_ctrl #(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [1:0]  size,
    input  logic        ld_unsigned,
    output logic [31:0] ReadData,
    output logic        ready,
    output logic        stall,
    output logic        misaligned
`ifdef DMEM_STATS_EN
    ,
    output logic [15:0] ld_count,
    output logic [15:0] st_count
`endif
);

    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t         state;
    state_t         next_state;
    logic [3:0]     cnt;

    // Captured copies of the request; inputs are don't-care after acceptance.
    logic           we_q;
    logic [AW+1:0]  addr_q;
    logic [31:0]    wdata_q;
    logic [1:0]     size_q;
    logic           uns_q;

    // Operands of the access in flight: live inputs while accepting in IDLE
    // (needed when the access completes on the acceptance edge itself).
    logic           op_we;
    logic [AW+1:0]  op_addr;
    logic [31:0]    op_wdata;
    logic [1:0]     op_size;
    logic           op_uns;
    logic           op_mis;
    logic [AW-1:0]  op_idx;
    logic           finishing;

    logic [31:0]    mem [DEPTH_WORDS];
    logic [31:0]    rd_word;
    logic [7:0]     lane8;
    logic [15:0]    lane16;
    logic [31:0]    load_val;
    logic [3:0]     wmask;
    logic [31:0]    wdata_rep;

    // Upper address bits only alias; fold them away explicitly.
    logic           unused_addr;
    assign unused_addr = ^addr[31:AW+2];

    assign op_we     = (state == IDLE) ? we           : we_q;
    assign op_addr   = (state == IDLE) ? addr[AW+1:0] : addr_q;
    assign op_wdata  = (state == IDLE) ? wdata        : wdata_q;
    assign op_size   = (state == IDLE) ? size         : size_q;
    assign op_uns    = (state == IDLE) ? ld_unsigned  : uns_q;
    assign op_idx    = op_addr[AW+1:2];
    assign finishing = (next_state == RESP);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Misalignment classification of the access in flight.
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        op_mis = 1'b1;
        case (op_size)
            2'b00:   op_mis = 1'b0;
            2'b01:   op_mis = op_addr[0];
            2'b10:   op_mis = |op_addr[1:0];
            default: op_mis = 1'b1;
        endcase
    end

    // Next-state logic.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (req) begin
                    if (WAIT_STATES == 0 || op_mis) next_state = RESP;
                    else                            next_state = BUSY;
                end
            end
            BUSY: begin
                if (cnt <= 4'd1) next_state = RESP;
            end
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // FSM outputs.
    always_comb begin
        ready = (state == RESP);
        stall = req & ~ready;
    end

    // Wait counter and request capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= 32'd0;
            size_q  <= 2'b00;
            uns_q   <= 1'b0;
        end else if (state == IDLE && req) begin
            cnt     <= 4'(WAIT_STATES);
            we_q    <= we;
            addr_q  <= addr[AW+1:0];
            wdata_q <= wdata;
            size_q  <= size;
            uns_q   <= ld_unsigned;
        end else if (state == BUSY) begin
            cnt     <= cnt - 4'd1;
        end
    end

    // Store lane mask and data replicated onto every lane.
    always_comb begin
        wmask     = 4'b0000;
        wdata_rep = op_wdata;
        case (op_size)
            2'b00: begin
                wmask     = 4'b0001 << op_addr[1:0];
                wdata_rep = {4{op_wdata[7:0]}};
            end
            2'b01: begin
                wmask     = op_addr[1] ? 4'b1100 : 4'b0011;
                wdata_rep = {2{op_wdata[15:0]}};
            end
            2'b10:   wmask = 4'b1111;
            default: wmask = 4'b0000;
        endcase
    end

    // Load lane selection and sign/zero extension.
    always_comb begin
        rd_word  = mem[op_idx];
        lane8    = rd_word[{op_addr[1:0], 3'b000} +: 8];
        lane16   = op_addr[1] ? rd_word[31:16] : rd_word[15:0];
        load_val = rd_word;
        case (op_size)
            2'b00:   load_val = op_uns ? {24'd0, lane8}  : {{24{lane8[7]}}, lane8};
            2'b01:   load_val = op_uns ? {16'd0, lane16} : {{16{lane16[15]}}, lane16};
            default: load_val = rd_word;
        endcase
    end

    // Byte-lane RAM write on the edge that completes an aligned store.
    always_ff @(posedge clk) begin
        // NOTE: RAM has no reset; only control state is reset, and rst blocks a pending write.
        if (!rst && finishing && op_we && !op_mis) begin
            for (int b = 0; b < 4; b++) begin
                if (wmask[b]) mem[op_idx][8*b +: 8] <= wdata_rep[8*b +: 8];
            end
        end
    end

    // Registered response: load data, zero on misaligned, error flag for RESP only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ReadData   <= 32'd0;
            misaligned <= 1'b0;
        end else if (finishing) begin
            misaligned <= op_mis;
            if (op_mis)      ReadData <= 32'd0;
            else if (!op_we) ReadData <= load_val;
        end else begin
            misaligned <= 1'b0;
        end
    end

`ifdef DMEM_STATS_EN
    // Saturating completion counters for aligned loads and stores.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ld_count <= 16'd0;
            st_count <= 16'd0;
        end else if (finishing && !op_mis) begin
            if (op_we) begin
                if (st_count != 16'hFFFF) st_count <= st_count + 16'd1;
            end else begin
                if (ld_count != 16'hFFFF) ld_count <= ld_count + 16'd1;
            end
        end
    end
`endif

endmodule
